// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the load/store buffer.
//
// Takes one load or store request at a time (address, width of 1/2/4 bytes,
// store data) and performs it as a little-endian, byte-serial sequence on a
// shared 8-bit RAM port arbitrated by mem_req_o/mem_gnt_i. Finishes with a
// one-cycle rdy_o pulse. Load data is returned raw and zero-extended.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   rst_c      synchronous pipeline flush, active high
//   rdy        global enable; when low every register holds
//   en_i       request valid (level, held until rdy_o is seen)
//   rw_i       1 = load, 0 = store
//   addr_i     byte address
//   data_i     store data, byte k goes to addr_i+k
//   width_i    access size in bytes (1, 2, 4; anything else is invalid)
//   rdy_o      one-cycle completion pulse
//   data_o     load result, valid while rdy_o is high
//   mem_req_o  RAM port request
//   mem_gnt_i  RAM port grant, held by the arbiter until mem_req_o falls
//   mem_a_o    RAM byte address
//   mem_dout_o RAM write byte
//   mem_wr_o   RAM write strobe
//   mem_din_i  RAM read byte, valid one cycle after its address
module dmem_responder #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_c,
  input  logic              rdy,
  input  logic              en_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [2:0]        width_i,
  output logic              rdy_o,
  output logic [31:0]       data_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  input  logic [7:0]        mem_din_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_XFER = 3'd2;
  localparam logic [2:0] S_TAIL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic logic width_ok(input logic [2:0] w);
    return (w == 3'd1) || (w == 3'd2) || (w == 3'd4);
  endfunction

  // Index of the last byte of an access of width w.
  function automatic logic [1:0] last_idx(input logic [2:0] w);
    case (w)
      3'd2:    return 2'd1;
      3'd4:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0: return w[7:0];
      2'd1: return w[15:8];
      2'd2: return w[23:16];
      2'd3: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (i)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      2'd3: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Wraps modulo 2^ADDR_W, so page/top-of-memory crossings need no special case.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [1:0] i);
    return base + ADDR_W'(i);
  endfunction

  // Control and output registers (reset)
  logic [2:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic              rdy_o_q, rdy_o_d;
  logic [31:0]       data_o_q, data_o_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;

  // Request and result holding registers (no reset needed)
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        width_q, width_d;
  logic [31:0]       result_q, result_d;

  logic [1:0]        last;
  logic [1:0]        nxt;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    rdy_o_d    = rdy_o_q;
    data_o_d   = data_o_q;
    mem_req_d  = mem_req_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    width_d    = width_q;
    result_d   = result_q;
    last       = last_idx(width_q);
    nxt        = cnt_q + 2'd1;

    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          rdy_o_d  = 1'b0;
          data_o_d = '0;
          // rst_c wins over a new request: nothing is latched.
          if (!rst_c && en_i) begin
            rw_d     = rw_i;
            addr_d   = addr_i;
            wdata_d  = data_i;
            width_d  = width_i;
            result_d = '0;
            flush_d  = 1'b0;
            cnt_d    = 2'd0;
            if (width_ok(width_i)) begin
              mem_req_d = 1'b1;
              state_d   = S_WAIT;
            end else begin
              // Invalid width completes immediately without touching memory.
              rdy_o_d = 1'b1;
              state_d = S_DONE;
            end
          end
        end

        S_WAIT: begin
          if (rst_c) begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end else if (mem_gnt_i) begin
            cnt_d      = 2'd0;
            state_d    = S_XFER;
            mem_a_d    = addr_q;
            mem_wr_d   = ~rw_q;
            mem_dout_d = rw_q ? 8'h00 : wdata_q[7:0];
          end
        end

        S_XFER: begin
          if (rw_q) begin
            if (rst_c) begin
              state_d    = S_IDLE;
              mem_req_d  = 1'b0;
              mem_a_d    = '0;
              mem_wr_d   = 1'b0;
              mem_dout_d = 8'h00;
            end else begin
              // Read data lags its address by one cycle, so byte cnt-1 arrives now.
              if (cnt_q != 2'd0) result_d = put_byte(result_q, cnt_q - 2'd1, mem_din_i);
              if (cnt_q == last) begin
                state_d = S_TAIL;
                mem_a_d = '0;
              end else begin
                cnt_d   = nxt;
                mem_a_d = byte_addr(addr_q, nxt);
              end
            end
          end else begin
            // A flushed store still finishes its bytes; it only loses the DONE pulse.
            flush_d = flush_q | rst_c;
            if (cnt_q == last) begin
              mem_req_d  = 1'b0;
              mem_a_d    = '0;
              mem_wr_d   = 1'b0;
              mem_dout_d = 8'h00;
              if (flush_d) begin
                state_d = S_IDLE;
              end else begin
                state_d  = S_DONE;
                rdy_o_d  = 1'b1;
                data_o_d = '0;
              end
            end else begin
              cnt_d      = nxt;
              mem_a_d    = byte_addr(addr_q, nxt);
              mem_wr_d   = 1'b1;
              mem_dout_d = get_byte(wdata_q, nxt);
            end
          end
        end

        S_TAIL: begin
          mem_req_d = 1'b0;
          if (rst_c) begin
            state_d = S_IDLE;
          end else begin
            result_d = put_byte(result_q, last, mem_din_i);
            state_d  = S_DONE;
            rdy_o_d  = 1'b1;
            data_o_d = result_d;
          end
        end

        S_DONE: begin
          // The pulse is registered on entry, so a flush here can only make sure
          // nothing follows it; IDLE is the next state either way.
          rdy_o_d  = 1'b0;
          data_o_d = '0;
          state_d  = S_IDLE;
        end

        default: begin
          state_d    = S_IDLE;
          rdy_o_d    = 1'b0;
          data_o_d   = '0;
          mem_req_d  = 1'b0;
          mem_a_d    = '0;
          mem_wr_d   = 1'b0;
          mem_dout_d = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      flush_q    <= 1'b0;
      rdy_o_q    <= 1'b0;
      data_o_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'h00;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      rdy_o_q    <= rdy_o_d;
      data_o_q   <= data_o_d;
      mem_req_q  <= mem_req_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    rw_q     <= rw_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    width_q  <= width_d;
    result_q <= result_d;
  end

  assign rdy_o      = rdy_o_q;
  assign data_o     = data_o_q;
  assign mem_req_o  = mem_req_q;
  assign mem_a_o    = mem_a_q;
  assign mem_dout_o = mem_dout_q;
  assign mem_wr_o   = mem_wr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: byte RAM and arbiter models, a scoreboard of
// expected completions (data and completion cycle), a vector table and a few
// hand-written multi-cycle sequences.
module tb_dmem_responder;
  localparam logic LD = 1'b1;
  localparam logic ST = 1'b0;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_c, rdy, en_i, rw_i;
  logic [31:0] addr_i, data_i;
  logic [2:0]  width_i;
  logic        rdy_o;
  logic [31:0] data_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_dout_o;
  logic        mem_wr_o;
  logic [7:0]  mem_din_i;

  dmem_responder #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rst_c(rst_c), .rdy(rdy),
    .en_i(en_i), .rw_i(rw_i), .addr_i(addr_i), .data_i(data_i), .width_i(width_i),
    .rdy_o(rdy_o), .data_o(data_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_a_o(mem_a_o),
    .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o), .mem_din_i(mem_din_i)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;        // advances only on enabled edges
  int wr_count = 0;
  int rdy_pulses = 0;

  always @(posedge clk) if (rdy) cyc <= cyc + 1;

  // Byte RAM indexed by the low 12 address bits; the addresses used never alias.
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (rst && rdy) begin
      mem_din_i <= ram[mem_a_o[11:0]];
      if (mem_wr_o) begin
        ram[mem_a_o[11:0]] <= mem_dout_o;
        wr_count <= wr_count + 1;
      end
    end
  end

  // Arbiter: grants gnt_delay cycles after the request, holds until it drops.
  logic gnt_tie;
  int   gnt_delay;
  logic gnt_q;
  int   wcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q <= 1'b0;
      wcnt  <= 0;
    end else if (rdy) begin
      if (!mem_req_o) begin
        gnt_q <= 1'b0;
        wcnt  <= 0;
      end else if (wcnt >= gnt_delay) gnt_q <= 1'b1;
      else wcnt <= wcnt + 1;
    end
  end
  assign mem_gnt_i = gnt_tie | gnt_q;

  logic gnt_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      assert (!(gnt_prev && mem_req_o && !mem_gnt_i))
        else begin
          failures++;
          $display("FAIL gnt_drop grant fell while request still high");
        end
    end
    gnt_prev <= mem_gnt_i & mem_req_o;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  exp_t got;
  always @(negedge clk) begin
    if (rst && rdy && rdy_o) begin
      rdy_pulses++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdy actual=1 required=0 cyc=%0d", cyc);
      end else begin
        got = sb.pop_front();
        chk("rdy_data", 64'(data_o), 64'(got.data));
        chk("rdy_cycle", 64'(cyc), 64'(got.cyc));
      end
    end
  end

  task automatic drive(input logic rw, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] w);
    rw_i = rw; addr_i = a; data_i = d; width_i = w; en_i = 1'b1;
  endtask

  // Drive a request and queue its completion; lat counts cycles from the cycle
  // in which IDLE samples en_i to the rdy_o cycle.
  task automatic issue(input logic rw, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] w, input logic [31:0] exp_d, input int lat,
                       input bit from_done);
    exp_t e;
    drive(rw, a, d, w);
    e.data = exp_d;
    e.cyc  = cyc + (from_done ? 1 : 0) + lat;
    sb.push_back(e);
  endtask

  task automatic wait_rdy(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (rdy && rdy_o) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL rdy_timeout actual=none required=pulse within %0d cycles", bound);
    end
  endtask

  task automatic xact(input logic rw, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] w, input logic [31:0] exp_d, input int lat,
                      input bit from_done);
    issue(rw, a, d, w, exp_d, lat, from_done);
    wait_rdy(40);
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  width;
    logic [31:0] exp_data;
    int          lat;
    int          exp_wr;
  } vec_t;
  vec_t vecs[15];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int wc;
    vecs[0]  = '{ST, 32'h0000_0100, 32'h4433_2211, 3'd4, 32'h0,         6, 4};
    vecs[1]  = '{ST, 32'h0000_0301, 32'h0000_005A, 3'd1, 32'h0,         3, 1};
    vecs[2]  = '{LD, 32'h0000_0100, 32'h0,         3'd4, 32'h4433_2211, 7, 0};
    vecs[3]  = '{ST, 32'h0000_02FF, 32'hDEAD_BEEF, 3'd2, 32'h0,         4, 2};
    vecs[4]  = '{LD, 32'h0000_02FF, 32'h0,         3'd2, 32'h0000_BEEF, 5, 0};
    vecs[5]  = '{LD, 32'h0000_0301, 32'h0,         3'd1, 32'h0000_005A, 4, 0};
    vecs[6]  = '{LD, 32'h0000_0102, 32'h0,         3'd1, 32'h0000_0033, 4, 0};
    vecs[7]  = '{LD, 32'h0000_0101, 32'h0,         3'd2, 32'h0000_3322, 5, 0};
    vecs[8]  = '{ST, 32'hFFFF_FFFE, 32'h0102_0304, 3'd4, 32'h0,         6, 4};
    vecs[9]  = '{LD, 32'hFFFF_FFFE, 32'h0,         3'd4, 32'h0102_0304, 7, 0};
    vecs[10] = '{LD, 32'hFFFF_FFFF, 32'h0,         3'd2, 32'h0000_0203, 5, 0};
    vecs[11] = '{LD, 32'h0000_0100, 32'h0,         3'd3, 32'h0,         1, 0};
    vecs[12] = '{ST, 32'h0000_0100, 32'hFFFF_FFFF, 3'd0, 32'h0,         1, 0};
    vecs[13] = '{LD, 32'h0000_0100, 32'h0,         3'd7, 32'h0,         1, 0};
    vecs[14] = '{LD, 32'h0000_0100, 32'h0,         3'd4, 32'h4433_2211, 7, 0};

    rst = 1'b0; rst_c = 1'b0; rdy = 1'b1; en_i = 1'b0; rw_i = 1'b0;
    addr_i = '0; data_i = '0; width_i = '0;
    gnt_tie = 1'b1; gnt_delay = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({rdy_o, mem_req_o, mem_wr_o, mem_dout_o}), 64'(0));
    chk("reset_data", 64'(data_o), 64'(0));
    chk("reset_addr", 64'(mem_a_o), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 15; i++) begin
      wc = wr_count;
      xact(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].width,
           vecs[i].exp_data, vecs[i].lat, 1'b0);
      chk($sformatf("vec%0d_writes", i), 64'(wr_count - wc), 64'(vecs[i].exp_wr));
      en_i = 1'b0;
      @(negedge clk);
    end

    // Load word: address sequence on the RAM port
    issue(LD, 32'h100, 32'h0, 3'd4, 32'h4433_2211, 7, 1'b0);
    @(negedge clk);
    chk("lw_wait", 64'({mem_req_o, mem_wr_o, mem_a_o}), {30'h0, 1'b1, 1'b0, 32'h0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("lw_addr%0d", k), 64'({mem_req_o, mem_wr_o, mem_a_o}),
          {30'h0, 1'b1, 1'b0, 32'h100 + 32'(k)});
    end
    wait_rdy(20);
    en_i = 1'b0;
    @(negedge clk);

    // Delayed grant: request held, port idle until the grant arrives
    gnt_tie = 1'b0; gnt_delay = 5;
    issue(LD, 32'h103, 32'h0, 3'd1, 32'h0000_0044, 10, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("gnt_wait%0d", k), 64'({mem_req_o, mem_gnt_i, mem_wr_o, mem_a_o}),
          {29'h0, 1'b1, 1'b0, 1'b0, 32'h0});
    end
    wait_rdy(30);
    en_i = 1'b0; gnt_tie = 1'b1; gnt_delay = 0;
    @(negedge clk);

    // Back-to-back: request swapped while rdy_o is high
    wc = wr_count;
    xact(ST, 32'h700, 32'h0000_0077, 3'd1, 32'h0, 3, 1'b0);
    xact(LD, 32'h700, 32'h0, 3'd1, 32'h0000_0077, 4, 1'b1);
    en_i = 1'b0;
    @(negedge clk);
    chk("b2b_writes", 64'(wr_count - wc), 64'(1));

    // rst_c beats a new request in IDLE
    drive(ST, 32'h100, 32'h0, 3'd1);
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0; en_i = 1'b0;
    chk("flush_idle_req", 64'(mem_req_o), 64'(0));
    @(negedge clk);

    // Flush a load at XFER cnt=1
    drive(LD, 32'h100, 32'h0, 3'd4);
    repeat (3) @(negedge clk);
    rst_c = 1'b1; en_i = 1'b0;
    @(negedge clk);
    rst_c = 1'b0;
    chk("flush_ld", 64'({mem_req_o, mem_wr_o, mem_a_o}), 64'(0));
    repeat (6) @(negedge clk);

    // Flush a store at XFER cnt=1: remaining bytes still go out
    wc = wr_count;
    drive(ST, 32'h600, 32'hCAFE_F00D, 3'd4);
    repeat (3) @(negedge clk);
    rst_c = 1'b1; en_i = 1'b0;
    @(negedge clk);
    rst_c = 1'b0;
    chk("flush_st_b2", 64'({mem_wr_o, mem_dout_o, mem_a_o}), {23'h0, 1'b1, 8'hFE, 32'h602});
    @(negedge clk);
    chk("flush_st_b3", 64'({mem_wr_o, mem_dout_o, mem_a_o}), {23'h0, 1'b1, 8'hCA, 32'h603});
    @(negedge clk);
    chk("flush_st_end", 64'({mem_req_o, mem_wr_o}), 64'(0));
    repeat (5) @(negedge clk);
    chk("flush_st_writes", 64'(wr_count - wc), 64'(4));
    xact(LD, 32'h600, 32'h0, 3'd4, 32'hCAFE_F00D, 7, 1'b0);
    en_i = 1'b0;
    @(negedge clk);

    // Global enable low for three cycles mid-XFER
    issue(LD, 32'h100, 32'h0, 3'd4, 32'h4433_2211, 7, 1'b0);
    repeat (3) @(negedge clk);
    chk("stall_pre", 64'(mem_a_o), 64'(32'h101));
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_hold%0d", k), 64'({mem_req_o, mem_a_o}), {31'h0, 1'b1, 32'h101});
    end
    rdy = 1'b1;
    wait_rdy(20);
    en_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-load clears outputs without a clock edge
    drive(LD, 32'h100, 32'h0, 3'd4);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_ctl", 64'({rdy_o, mem_req_o, mem_wr_o, mem_dout_o}), 64'(0));
    chk("arst_data_addr", {data_o, mem_a_o}, 64'(0));
    en_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xact(LD, 32'h100, 32'h0, 3'd4, 32'h4433_2211, 7, 1'b0);
    en_i = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 64'(0));
    chk("rdy_pulses", 64'(rdy_pulses), 64'(22));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
